// File: rtl/fft_n16_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed 16-point FFT frames in, natural bin order out.
// Output is registered one cycle after the read address; there is no backpressure.
module fft_n16_bitrev_reorder #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  input  logic [2*W-1:0] i_data,
  output logic           o_valid,
  output logic [2*W-1:0] o_data,
  output logic [3:0]     o_index,
  output logic           o_last,
  output logic           o_busy
);

  typedef enum logic {IDLE, READ} state_t;

  state_t         state_q, state_d;
  logic [3:0]     wr_cnt_q, wr_cnt_d;
  logic           wr_bank_q, wr_bank_d;
  logic [1:0]     full_q, full_d;
  logic           rd_bank_q, rd_bank_d;
  logic [3:0]     rd_cnt_q, rd_cnt_d;
  logic           o_valid_d;
  logic [2*W-1:0] o_data_d;
  logic [3:0]     o_index_d;
  logic           o_last_d;
  logic [3:0]     wr_addr;

  logic [2*W-1:0] mem_q [2][16];

  assign wr_addr = {wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2], wr_cnt_q[3]};
  assign o_busy  = (state_q == READ) | (|full_q);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      mem_q[wr_bank_q][wr_addr] <= i_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data;
    o_index_d = o_index;
    o_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = READ;
          rd_cnt_d = 4'd0;
        end
      end
      READ: begin
        o_valid_d = 1'b1;
        o_data_d  = mem_q[rd_bank_q][rd_cnt_q];
        o_index_d = rd_cnt_q;
        o_last_d  = (rd_cnt_q == 4'd15);
        rd_cnt_d  = rd_cnt_q + 4'd1;
        if (rd_cnt_q == 4'd15) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          if (!full_q[~rd_bank_q]) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied after the read-side clear so a same-edge set takes priority.
    if (i_valid) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_cnt_q  <= 4'd0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 4'd0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_index   <= 4'd0;
      o_last    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      o_valid   <= o_valid_d;
      o_data    <= o_data_d;
      o_index   <= o_index_d;
      o_last    <= o_last_d;
    end
  end

endmodule

// File: tb/tb_fft_n16_bitrev_reorder.sv
// Scoreboard bench for the bit-reverse reorder stage: driver pushes expectations, monitor pops on o_valid.
module tb_fft_n16_bitrev_reorder;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_valid;
  logic [2*W-1:0] i_data;
  logic           o_valid;
  logic [2*W-1:0] o_data;
  logic [3:0]     o_index;
  logic           o_last;
  logic           o_busy;

  fft_n16_bitrev_reorder #(.W(W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .o_index(o_index),
    .o_last(o_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   frame_pos = 0;
  int   last_cap = 0;
  int   run_cur = 0;
  int   run_max = 0;

  int pat_tbl [16] = '{1, 9, 5, 13, 3, 11, 7, 15, 2, 10, 6, 14, 4, 12, 8, 16};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int br4(input int j);
    return ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
  endfunction

  task automatic push_exp(input logic [31:0] d, input int k);
    exp_t x;
    x.d = d;
    x.k = 4'(k);
    x.l = (k == 15);
    sbq.push_back(x);
  endtask

  task automatic send(input logic [31:0] d);
    i_valid = 1'b1;
    i_data  = d;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = '0;
    frame_pos++;
    if (frame_pos == 16) begin
      frame_pos = 0;
      last_cap  = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sbq.delete();
    frame_pos = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: %0d outputs still pending, required 0", name, sbq.size());
    end
    idle(3);
  endtask

  // Monitor: every valid output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_valid) begin
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got o_index=%0d o_data=%h, required no output", o_index, o_data);
      end else begin
        e = sbq.pop_front();
        if ({o_data, o_index, o_last} !== e) begin
          fails++;
          $display("FAIL out_k%0d: got data=%h idx=%0d last=%0d, required data=%h idx=%0d last=%0d",
                   e.k, o_data, o_index, o_last, e.d, e.k, e.l);
        end
      end
      if (o_index == 4'd0) begin
        tests++;
        if (cyc != last_cap + 2) begin
          fails++;
          $display("FAIL latency: first output %0d cycles after last capture, required 2", cyc - last_cap);
        end
      end
    end else begin
      run_cur = 0;
    end
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    tests++;
    if ({o_valid, o_data, o_index, o_last, o_busy} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%0d d=%h i=%0d l=%0d b=%0d, required all 0",
               o_valid, o_data, o_index, o_last, o_busy);
    end

    // Idle stability.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_last !== 1'b0 || o_data !== '0) begin
        fails++;
        $display("FAIL idle_c%0d: got v=%0d b=%0d l=%0d d=%h, required all 0",
                 c, o_valid, o_busy, o_last, o_data);
      end
    end
    @(posedge clk);
    #1;

    // Single frame with gapped input.
    for (int j = 0; j < 16; j++) push_exp({16'(j * 1000), 16'(br4(j))}, j);
    for (int j = 0; j < 16; j++) begin
      send({16'(br4(j) * 1000), 16'(j)});
      idle(1);
    end
    drain("gapped");

    // Two frames at full rate must stream without a gap.
    for (int j = 0; j < 16; j++) push_exp({16'(j * 1000), 16'(br4(j))}, j);
    for (int j = 0; j < 16; j++) push_exp({16'(j * 1000 + 16000), 16'(br4(j))}, j);
    run_max = 0;
    for (int j = 0; j < 16; j++) send({16'(br4(j) * 1000), 16'(j)});
    for (int j = 0; j < 16; j++) send({16'(br4(j) * 1000 + 16000), 16'(j)});
    drain("b2b");
    tests++;
    if (run_max != 32) begin
      fails++;
      $display("FAIL b2b_contiguous: got run of %0d valid cycles, required 32", run_max);
    end

    // Arrival-order pattern 1..16.
    for (int k = 0; k < 16; k++) push_exp({16'(pat_tbl[k]), 16'h0000}, k);
    for (int j = 0; j < 16; j++) send({16'(j + 1), 16'h0000});
    drain("pattern");

    // Reset after a partial frame: only the following full frame may appear.
    for (int j = 0; j < 7; j++) send({16'h7777, 16'(j)});
    do_reset();
    for (int j = 0; j < 16; j++) push_exp({16'(j * 1000 + 5000), 16'(br4(j))}, j);
    for (int j = 0; j < 16; j++) send({16'(br4(j) * 1000 + 5000), 16'(j)});
    drain("rst_midframe");
    idle(20);

    // Reset during readout at bin 5.
    for (int j = 0; j < 16; j++) push_exp({16'(j + 100), 16'(br4(j))}, j);
    for (int j = 0; j < 16; j++) send({16'(br4(j) + 100), 16'(j)});
    begin
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
        @(negedge clk);
        n++;
        if (o_valid && o_index == 4'd5) seen = 1'b1;
      end
      #1;
      tests++;
      if (!seen) begin
        fails++;
        $display("FAIL rst_readout_wait: o_index=5 not seen within 100 cycles, required seen");
      end
    end
    do_reset();
    tests++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_readout_valid: got o_valid=%0d after reset, required 0", o_valid);
    end
    idle(20);
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_readout_busy: got o_busy=%0d, required 0", o_busy);
    end
    for (int j = 0; j < 16; j++) push_exp({16'(j * 7), 16'(br4(j))}, j);
    for (int j = 0; j < 16; j++) send({16'(br4(j) * 7), 16'(j)});
    drain("after_rst_readout");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
